// File: rtl/piezo_pkg.sv
// Shared types, note/duration constants and tune tables for the piezo scheduler.
// Consumers: tone_gen and piezo_sched (optional PIEZO_PREEMPT_EN build).
package piezo_pkg;

    typedef enum logic [2:0] {
        REST,
        G6,
        C7,
        E7,
        G7
    } note_t;

    typedef enum logic [1:0] {
        Q,
        H,
        DH,
        W
    } dur_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    typedef struct packed {
        note_t note;
        dur_t  dur;
    } tune_ent_t;

    localparam int N_TUNES   = 3;
    localparam int MAX_NOTES = 6;

    localparam logic [14:0] DIV_G6 = 15'd31888;
    localparam logic [14:0] DIV_C7 = 15'd23890;
    localparam logic [14:0] DIV_E7 = 15'd18960;
    localparam logic [14:0] DIV_G7 = 15'd15944;

    localparam logic [24:0] DUR_Q  = 25'd4194304;
    localparam logic [24:0] DUR_H  = 25'd8388608;
    localparam logic [24:0] DUR_DH = 25'd12582912;
    localparam logic [24:0] DUR_W  = 25'd16777216;

    // Row 0 fanfare, row 1 low battery, row 2 fault; unused slots are rests.
    localparam tune_ent_t TUNES [N_TUNES][MAX_NOTES] = '{
        '{'{G6, H}, '{C7, H}, '{E7, H},
          '{G7, DH}, '{E7, Q}, '{G7, W}},
        '{'{E7, Q}, '{REST, Q}, '{E7, Q},
          '{REST, Q}, '{E7, Q}, '{REST, Q}},
        '{'{G7, Q}, '{G6, Q}, '{G7, Q},
          '{G6, Q}, '{REST, Q}, '{REST, Q}}
    };

    localparam logic [2:0] TUNE_LEN [N_TUNES] = '{
        3'd6, 3'd6, 3'd4
    };

    function automatic logic [14:0] note_div(input note_t n);
        logic [14:0] d;
        d = 15'd0;
        unique case (n)
            G6:      d = DIV_G6;
            C7:      d = DIV_C7;
            E7:      d = DIV_E7;
            G7:      d = DIV_G7;
            default: d = 15'd0;
        endcase
        return d;
    endfunction

    function automatic logic [24:0] dur_clk(input dur_t t);
        logic [24:0] d;
        d = DUR_Q;
        unique case (t)
            Q:       d = DUR_Q;
            H:       d = DUR_H;
            DH:      d = DUR_DH;
            W:       d = DUR_W;
            default: d = DUR_Q;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] pick_hi(input logic [2:0] p);
        logic [2:0] g;
        g = 3'b000;
        if (p[2])
            g = 3'b100;
        else if (p[1])
            g = 3'b010;
        else if (p[0])
            g = 3'b001;
        return g;
    endfunction

    // Requesters that outrank the given one-hot grant.
    function automatic logic [2:0] hi_mask(input logic [2:0] g);
        logic [2:0] m;
        m = 3'b000;
        unique case (1'b1)
            g[0]:    m = 3'b110;
            g[1]:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: period counter, half-period compare and
// registered complementary outputs; silent while disabled or resting.
module tone_gen
    import piezo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  clr,
    input  note_t note,
    output logic  piezo,
    output logic  piezo_n
);

    logic [14:0] freq_cnt;
    logic [14:0] div;
    logic [14:0] half;
    logic        tone_on;
    logic        hold;

    assign div     = note_div(note);
    assign half    = div >> 1;
    assign tone_on = (freq_cnt < half);
    assign hold    = rst || !en || clr || (note == REST);

    always_ff @(posedge clk) begin
        if (hold) begin
            freq_cnt <= 15'd0;
            piezo    <= 1'b0;
            piezo_n  <= 1'b0;
        end else begin
            if (freq_cnt == div - 15'd1)
                freq_cnt <= 15'd0;
            else
                freq_cnt <= freq_cnt + 15'd1;
            piezo   <= tone_on;
            piezo_n <= ~tone_on;
        end
    end

endmodule

// File: rtl/piezo_sched.sv
// Piezo scheduler: latches tune requests, grants the highest priority one and
// walks its note table. Optional PIEZO_PREEMPT_EN lets higher tunes abort.
module piezo_sched
    import piezo_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       busy,
    output logic [2:0] grant,
    output logic       done,
    output logic       piezo,
    output logic       piezo_n
);

    localparam logic [24:0] STEP =
        (FAST_SIM != 0) ? 25'd16 : 25'd1;

    state_t      state;
    state_t      state_d;
    logic [2:0]  pending;
    logic [2:0]  grant_q;
    logic [2:0]  grant_nxt;
    logic [2:0]  clr_mask;
    logic [2:0]  idx;
    logic [24:0] dur_cnt;
    logic [1:0]  tune_id;
    tune_ent_t   cur;
    logic        start;
    logic        note_end;
    logic        last_note;
    logic        preempt;
    logic        tone_en;

    always_comb begin
        tune_id = 2'd0;
        unique case (1'b1)
            grant_q[1]: tune_id = 2'd1;
            grant_q[2]: tune_id = 2'd2;
            default:    tune_id = 2'd0;
        endcase
    end

    assign cur       = TUNES[tune_id][idx];
    assign last_note = (idx == TUNE_LEN[tune_id] - 3'd1);
    assign note_end  = (dur_cnt >= dur_clk(cur.dur) - STEP);
    assign grant_nxt = pick_hi(pending);
    assign start     = (state == IDLE) && (pending != 3'b000);
    assign clr_mask  = start ? grant_nxt : 3'b000;

`ifdef PIEZO_PREEMPT_EN
    assign preempt = (state == PLAY) &&
                     ((pending & hi_mask(grant_q)) != 3'b000);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (pending != 3'b000)
                    state_d = PLAY;
            end
            PLAY: begin
                if (preempt)
                    state_d = IDLE;
                else if (note_end && last_note)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set wins over the grant clear, so a re-request while granted queues a replay.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 3'b000;
            grant_q <= 3'b000;
            idx     <= 3'd0;
            dur_cnt <= 25'd0;
        end else begin
            pending <= (pending & ~clr_mask) | req;
            if (start) begin
                grant_q <= grant_nxt;
                idx     <= 3'd0;
                dur_cnt <= 25'd0;
            end else if (state == PLAY && !preempt) begin
                if (note_end) begin
                    dur_cnt <= 25'd0;
                    if (!last_note)
                        idx <= idx + 3'd1;
                end else begin
                    dur_cnt <= dur_cnt + STEP;
                end
            end
        end
    end

    always_comb begin
        busy  = (state == PLAY);
        done  = (state == DONE);
        grant = (state == IDLE) ? 3'b000 : grant_q;
    end

    // Tone runs only while staying in PLAY, so exits leave the pads quiet.
    assign tone_en = (state == PLAY) && (state_d == PLAY);

    tone_gen u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .clr     (note_end),
        .note    (cur.note),
        .piezo   (piezo),
        .piezo_n (piezo_n)
    );

endmodule

// File: tb/tb_piezo_sched.sv
// Directed bench for piezo_sched; long notes are fast-forwarded by depositing
// a value close to the note end into the duration counter.
module tb_piezo_sched;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       busy;
    logic [2:0] grant;
    logic       done;
    logic       piezo;
    logic       piezo_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] skip_val;

    localparam int DQ = 4194304;
    localparam int DH_ = 8388608;
    localparam int DDH = 12582912;
    localparam int DW = 16777216;
    localparam int FAN_D [6] = '{DH_, DH_, DH_, DDH, DQ, DW};
    localparam int K = 4;

    piezo_sched #(.FAST_SIM(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .busy    (busy),
        .grant   (grant),
        .done    (done),
        .piezo   (piezo),
        .piezo_n (piezo_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [2:0] r);
        @(negedge clk);
        req = r;
        @(negedge clk);
        req = 3'b000;
    endtask

    // Leave k cycles of the current note.
    task automatic skip_note(input int d, input int k);
        @(negedge clk);
        skip_val = 25'(d - 16 * k);
        force dut.dur_cnt = skip_val;
        release dut.dur_cnt;
    endtask

    task automatic count_edges(output int n);
        logic [2:0] i0;
        i0 = dut.idx;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (n < 64 && dut.idx == i0 &&
                   done !== 1'b1 && busy === 1'b1);
    endtask

    task automatic high_run(output int hi);
        int w;
        w = 0;
        while (piezo !== 1'b1 && w < 40000) begin
            @(negedge clk);
            w++;
        end
        hi = 0;
        while (piezo === 1'b1 && hi < 40000) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, grant, done, piezo, piezo_n} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_out got %b want 0",
                     {busy, grant, done, piezo, piezo_n});
        end
        n_checks++;
        if (dut.pending !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pend got %b want 000", dut.pending);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (piezo !== 1'b0 || piezo_n !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet got %b%b%b want 000",
                     piezo, piezo_n, busy);
        end
    endtask

    task automatic test_fanfare();
        int hi, lo, bad, n;
        pulse(3'b001);
        n_checks++;
        if (dut.pending !== 3'b001 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fan_pend got %b/%b want 001/0",
                     dut.pending, busy);
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b001 || busy !== 1'b1 || piezo !== 1'b0) begin
            n_fail++;
            $display("FAIL fan_grant got %b/%b/%b want 001/1/0",
                     grant, busy, piezo);
        end
        @(negedge clk);
        n_checks++;
        if (piezo !== 1'b1 || piezo_n !== 1'b0) begin
            n_fail++;
            $display("FAIL fan_rise got %b%b want 10", piezo, piezo_n);
        end
        hi = 0;
        lo = 0;
        bad = 0;
        while (piezo === 1'b1 && hi < 40000) begin
            hi++;
            if (piezo_n !== 1'b0) bad++;
            @(negedge clk);
        end
        while (piezo === 1'b0 && lo < 40000) begin
            lo++;
            if (piezo_n !== 1'b1) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (hi !== 15944) begin
            n_fail++;
            $display("FAIL g6_high got %0d want 15944", hi);
        end
        n_checks++;
        if (hi + lo !== 31888) begin
            n_fail++;
            $display("FAIL g6_period got %0d want 31888", hi + lo);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL g6_compl got %0d bad want 0", bad);
        end
        for (int i = 0; i < 6; i++) begin
            skip_note(FAN_D[i], K);
            count_edges(n);
            n_checks++;
            if (n !== K) begin
                n_fail++;
                $display("FAIL fan_note%0d got %0d want %0d", i, n, K);
            end
        end
        n_checks++;
        if (done !== 1'b1 || grant !== 3'b001 || piezo !== 1'b0) begin
            n_fail++;
            $display("FAIL fan_done got %b/%b/%b want 1/001/0",
                     done, grant, piezo);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || grant !== 3'b000) begin
            n_fail++;
            $display("FAIL fan_idle got %b/%b/%b want 0/0/000",
                     done, busy, grant);
        end
    endtask

    task automatic test_priority();
        int hi, n, bad;
        pulse(3'b101);
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b100 || dut.pending !== 3'b001) begin
            n_fail++;
            $display("FAIL prio_grant got %b/%b want 100/001",
                     grant, dut.pending);
        end
        high_run(hi);
        n_checks++;
        if (hi !== 7972) begin
            n_fail++;
            $display("FAIL g7_high got %0d want 7972", hi);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            skip_note(DQ, K);
            count_edges(n);
            if (n !== K) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL fault_notes got %0d bad want 0", bad);
        end
        n_checks++;
        if (done !== 1'b1 || grant !== 3'b100) begin
            n_fail++;
            $display("FAIL fault_done got %b/%b want 1/100", done, grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || grant !== 3'b000) begin
            n_fail++;
            $display("FAIL prio_gap got %b/%b want 0/000", busy, grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || grant !== 3'b001) begin
            n_fail++;
            $display("FAIL prio_next got %b/%b want 1/001", busy, grant);
        end
        do_reset();
    endtask

    // Leaves the low-battery tune just started.
    task automatic test_preempt();
        int n, bad, seen_done;
        pulse(3'b001);
        @(negedge clk);
        skip_note(FAN_D[0], 2);
        count_edges(n);
        n_checks++;
        if (n !== 2 || dut.idx !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_c7 got %0d/%0d want 2/1", n, dut.idx);
        end
        pulse(3'b010);
`ifdef PIEZO_PREEMPT_EN
        @(negedge clk);
        n_checks++;
        if ({busy, grant, done, piezo, piezo_n} !== 7'd0) begin
            n_fail++;
            $display("FAIL pre_abort got %b want 0",
                     {busy, grant, done, piezo, piezo_n});
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_start got %b/%b want 010/1", grant, busy);
        end
        seen_done = 0;
`else
        repeat (2) @(negedge clk);
        n_checks++;
        if (grant !== 3'b001 || dut.pending !== 3'b010) begin
            n_fail++;
            $display("FAIL pre_wait got %b/%b want 001/010",
                     grant, dut.pending);
        end
        bad = 0;
        for (int i = 1; i < 6; i++) begin
            skip_note(FAN_D[i], 2);
            count_edges(n);
            if (n !== 2) bad++;
        end
        seen_done = done ? 1 : 0;
        n_checks++;
        if (bad !== 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_fin got %0d/%b want 0/1", bad, done);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 3'b010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_next got %b/%b want 010/1", grant, busy);
        end
`endif
        n_checks++;
        if (dut.idx !== 3'd0 || dut.pending !== 3'b000) begin
            n_fail++;
            $display("FAIL pre_state got %0d/%b want 0/000 (done %0d)",
                     dut.idx, dut.pending, seen_done);
        end
    endtask

    task automatic test_rest_queue();
        int hi, n, bad, quiet;
        high_run(hi);
        n_checks++;
        if (hi !== 9480) begin
            n_fail++;
            $display("FAIL e7_high got %0d want 9480", hi);
        end
        pulse(3'b010);
        pulse(3'b010);
        n_checks++;
        if (dut.pending !== 3'b010) begin
            n_fail++;
            $display("FAIL queue_pend got %b want 010", dut.pending);
        end
        bad = 0;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1 || i == 3) begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (piezo !== 1'b0 || piezo_n !== 1'b0) quiet++;
                end
            end
            skip_note(DQ, K);
            count_edges(n);
            if (n !== K) bad++;
        end
        n_checks++;
        if (quiet !== 0) begin
            n_fail++;
            $display("FAIL rest_quiet got %0d bad want 0", quiet);
        end
        n_checks++;
        if (bad !== 0 || done !== 1'b1 || grant !== 3'b010) begin
            n_fail++;
            $display("FAIL batt_done got %0d/%b/%b want 0/1/010",
                     bad, done, grant);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy !== 1'b1 || grant !== 3'b010 ||
            dut.pending !== 3'b000) begin
            n_fail++;
            $display("FAIL replay got %b/%b/%b want 1/010/000",
                     busy, grant, dut.pending);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            skip_note(DQ, K);
            count_edges(n);
            if (n !== K) bad++;
        end
        n_checks++;
        if (bad !== 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL replay_done got %0d/%b want 0/1", bad, done);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dut.pending !== 3'b000) begin
            n_fail++;
            $display("FAIL one_replay got %b/%b want 0/000",
                     busy, dut.pending);
        end
    endtask

    task automatic test_reset_mid();
        pulse(3'b001);
        repeat (4) @(negedge clk);
        n_checks++;
        if (piezo !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_play got %b/%b want 1/1", piezo, busy);
        end
        pulse(3'b010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, grant, done, piezo, piezo_n} !== 7'd0 ||
            dut.pending !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_rst got %b/%b want 0/000",
                     {busy, grant, done, piezo, piezo_n}, dut.pending);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || grant !== 3'b000 || piezo !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after got %b/%b/%b want 0/000/0",
                     busy, grant, piezo);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        skip_val = 25'd0;
        test_reset();
        test_fanfare();
        test_priority();
        test_preempt();
        test_rest_queue();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piezo_sched.md
# piezo_sched

- Schedules the shared piezo output between three sound requesters: charge fanfare, low-battery alert and fault alarm.
- Latches request pulses, grants the highest-priority pending tune, and steps through that tune's note/duration table.
- Drives one tone generator that produces `piezo`/`piezo_n`.
- Sits between the system controller and the piezo pads. It replaces per-tune drivers so that only one block ever drives the buzzer.

## Interface
- `FAST_SIM`, default 1: when 1, the duration counter advances by 16 per clock; when 0, it advances by 1.
- `clk`  in  1  50 MHz system clock. One clock domain; reset `rst` is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `req`  in  3  request pulses. [0] charge fanfare, [1] low battery, [2] fault. Priority is [2] > [1] > [0].
- `busy`  out  1  high while a tune is playing.
- `grant`  out  3  one-hot index of the tune currently playing; 0 when idle.
- `done`  out  1  one-cycle pulse when a tune completes naturally.
- `piezo`  out  1  tone output.
- `piezo_n`  out  1  complementary tone output; 0 when idle or during a rest.

## Operation
- **Pending latch.** `pending[i]` is set by `req[i]` and cleared when tune i is granted. If set and clear occur in the same cycle, set wins. Requesting the tune that is already playing queues one replay. Multiple pulses while pending collapse into one request.
- **Tunes** (D = duration in clocks; Q = 2^22, H = 2^23, DH = 3·2^22, W = 2^24):
  - Fanfare: G6 H, C7 H, E7 H, G7 DH, E7 Q, G7 W.
  - Low battery: E7 Q, REST Q, E7 Q, REST Q, E7 Q, REST Q.
  - Fault: G7 Q, G6 Q, G7 Q, G6 Q.
- **Dividers** (clocks per period): G6 31888, C7 23890, E7 18960, G7 15944. The half-period threshold is the divider >> 1.
- **State machine** (states IDLE, PLAY, DONE):
  - IDLE: `busy` = 0, `grant` = 0, and both piezo outputs are 0. If `pending` ≠ 0, the next state is PLAY: grant the highest pending tune, set note index to 0, clear the duration counter and frequency counter.
  - PLAY:
    - `dur_cnt` increments by the step (16 or 1).
    - When `dur_cnt` ≥ D−step, the note ends.
    - If this is the last note, go to DONE. Otherwise increment the index and clear both counters.
  - DONE: `done` = 1 for this cycle. `grant` holds its value, and the piezo outputs are 0. The next state is IDLE.
- **Tone generation.**
  - `freq_cnt` counts from 0 to div−1 and then wraps.
  - `piezo` is registered as (`freq_cnt` < div>>1).
  - `piezo_n` = ~`piezo` while a non-rest note plays.
  - For a REST note, both outputs are 0 and `freq_cnt` is held at 0.
- **Widths.** `dur_cnt` is 25 bits; `freq_cnt` is 15 bits; the note index is 3 bits.
- **Reset at any time.** The block returns to IDLE, `pending` is cleared, counters are cleared, and all outputs are 0, on the next edge.

## Timing
- Reset values: `busy` 0, `grant` 0, `done` 0, `piezo` 0, `piezo_n` 0.
- `req[i]` is high in cycle N, so `pending[i]` is set at edge N+1. State becomes PLAY, with `busy` and `grant` valid, at edge N+2. `piezo` goes 1 at edge N+3.
- Each note lasts exactly D/step cycles in PLAY. Fanfare in PLAY takes 3670016 cycles with FAST_SIM=1.
- `done` rises exactly one cycle after the final note ends.
- Back-to-back tunes: if `pending` is nonzero while in DONE, PLAY re-enters two cycles after DONE (DONE → IDLE → PLAY).
- Idle outputs are constant; the block never glitches `piezo` while idle.

## Configuration
- Macro `PIEZO_PREEMPT_EN`.
- **Defined:**
  - In PLAY, if `pending` holds a bit of higher priority than `grant`, the current tune aborts on that cycle.
  - The next cycle is IDLE with piezo outputs 0, and the new tune is granted the cycle after.
  - An aborted tune gets no `done` pulse and is not re-queued.
- **Undefined:** higher-priority requests wait in `pending` until the current tune reaches DONE.

## Structure
- Package `piezo_pkg` holds:
  - `note_t` enum (REST, G6, C7, E7, G7) and `dur_t` enum (Q, H, DH, W).
  - `state_t` enum.
  - Divider and duration constants.
  - Tune tables as constant arrays of {note, dur}, with tune lengths {6, 6, 4}.
- Sub-module `tone_gen`:
  - Holds `freq_cnt`, the half-period compare, and the registered `piezo`.
  - Inputs: `clk`, `rst`, `en`, `clr`, `note`.
  - Outputs: `piezo`, `piezo_n`.
- `piezo_sched` holds `pending`, the FSM, the index, and `dur_cnt`.

## Test plan
- Single fanfare, FAST_SIM=1: pulse `req[0]` → `grant`=001 two cycles later. The 6 note boundaries fall at cumulative cycles 524288, 1048576, 1572864, 2359296, 2621440 and 3670016. `done` pulses once.
- Tone check: during the G6 note, measure `piezo` → period 31888 clocks, high for 15944 clocks; `piezo_n` is the complement.
- Priority: pulse `req[0]` and `req[2]` in the same cycle → fault tune plays (1048576 cycles), then fanfare starts 2 cycles after `done`.
- Preemption: during the fanfare's C7 note, pulse `req[1]`:
  - With `PIEZO_PREEMPT_EN`: battery tune starts 3 cycles later, and no `done` pulse is issued for the fanfare.
  - Without it: battery tune starts 2 cycles after the fanfare's `done`.
- Rest and queueing: during the battery tune's REST notes, `piezo`=`piezo_n`=0. Pulse `req[1]` twice mid-tune → exactly one replay follows.
- Reset mid-tune: assert `rst` for one cycle during PLAY → next edge all outputs are 0 and `pending` is 0. No tune resumes.
